// File: rtl/demux_rr_sequencer_if.sv
// rtl/demux_rr_sequencer_if.sv - bit-stream and demux-drive bundle for demux_rr_sequencer
interface demux_rr_sequencer_if;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic [3:0] ch_mask;
    logic       a;
    logic [1:0] s;
    logic       out_valid;
    logic       rot_done;
    logic       err_nomask;

    modport master (
        output in_valid, in_bit, ch_mask,
        input  in_ready, a, s, out_valid, rot_done, err_nomask
    );

    modport slave (
        input  in_valid, in_bit, ch_mask,
        output in_ready, a, s, out_valid, rot_done, err_nomask
    );
endinterface

// File: rtl/demux_rr_sequencer.sv
// rtl/demux_rr_sequencer.sv - round-robin bit distributor driving a 1-to-4 demux with dwell hold
module demux_rr_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_rr_sequencer_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    ptr;
    logic [1:0]    s_q;
    logic          a_q;
    logic          last;

    logic          mask_any;
    logic          dwell_end;
    logic          ready;
    logic          accept;
    logic [1:0]    nxt;
    logic [1:0]    idx;
    logic          found;
    logic          last_nxt;

    assign mask_any  = |bus.ch_mask;
    assign dwell_end = (state == HOLD) && (cnt == '0);
    assign ready     = rst_n && mask_any && ((state == IDLE) || dwell_end);
    assign accept    = bus.in_valid && ready;

    // Cyclic scan starting just after the last-served channel; i == 4 wraps back onto ptr itself.
    always_comb begin
        nxt   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && bus.ch_mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    // The bit closes a rotation when no enabled channel sits above the one just picked.
    always_comb begin
        last_nxt = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ((j > int'(nxt)) && bus.ch_mask[j]) begin
                last_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 2'd3;
            a_q   <= 1'b0;
            s_q   <= 2'd0;
            last  <= 1'b0;
        end else if (accept) begin
            state <= HOLD;
            a_q   <= bus.in_bit;
            s_q   <= nxt;
            ptr   <= nxt;
            cnt   <= CW'(DWELL - 1);
            last  <= last_nxt;
        end else if (state == HOLD) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state <= IDLE;
                a_q   <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.a          = a_q;
    assign bus.s          = s_q;
    assign bus.out_valid  = (state == HOLD);
    assign bus.rot_done   = dwell_end && last;
    assign bus.err_nomask = bus.in_valid && !mask_any;
endmodule

// File: tb/tb_demux_rr_sequencer.sv
// tb/tb_demux_rr_sequencer.sv - self-checking bench for demux_rr_sequencer (DWELL=4 and DWELL=1)
module tb_demux_rr_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic [3:0] ch_mask;
    bit         chk_en = 1'b0;
    int         tests  = 0;
    int         failed = 0;

    always #5 clk = ~clk;

    demux_rr_sequencer_if bus4();
    demux_rr_sequencer_if bus1();

    assign bus4.in_valid = in_valid;
    assign bus4.in_bit   = in_bit;
    assign bus4.ch_mask  = ch_mask;
    assign bus1.in_valid = in_valid;
    assign bus1.in_bit   = in_bit;
    assign bus1.ch_mask  = ch_mask;

    demux_rr_sequencer #(.DWELL(4), .CW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    demux_rr_sequencer #(.DWELL(1), .CW(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        bit hold;
        int rem;
        int ptr;
        bit a;
        int s;
        bit last;
    } ms_t;

    ms_t m4, m1;

    function automatic ms_t mreset();
        ms_t n;
        n.hold = 0; n.rem = 0; n.ptr = 3; n.a = 0; n.s = 0; n.last = 0;
        return n;
    endfunction

    function automatic bit pready(ms_t m, bit rstn, logic [3:0] mask);
        return rstn && (mask != 4'd0) && (!m.hold || m.rem == 1);
    endfunction

    function automatic int pick(int ptr, logic [3:0] mask);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return ptr;
    endfunction

    function automatic ms_t mstep(ms_t m, int dwell, bit rstn, bit v, bit b, logic [3:0] mask);
        ms_t n = m;
        if (!rstn) return mreset();
        if (v && pready(m, rstn, mask)) begin
            n.s    = pick(m.ptr, mask);
            n.ptr  = n.s;
            n.a    = b;
            n.hold = 1;
            n.rem  = dwell;
            n.last = 1;
            for (int j = n.s + 1; j < 4; j++) if (mask[j]) n.last = 0;
        end else if (m.hold) begin
            if (m.rem == 1) begin
                n.hold = 0;
                n.a    = 0;
            end else begin
                n.rem = m.rem - 1;
            end
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model(string tag, ms_t m, logic ir, logic a, logic [1:0] s,
                             logic ov, logic rd, logic err);
        chk({tag, ".in_ready"},   ir,  pready(m, rst_n, ch_mask));
        chk({tag, ".out_valid"},  ov,  m.hold);
        chk({tag, ".a"},          a,   m.hold ? m.a : 1'b0);
        chk({tag, ".s"},          s,   m.s);
        chk({tag, ".rot_done"},   rd,  m.hold && m.rem == 1 && m.last);
        chk({tag, ".err_nomask"}, err, in_valid && ch_mask == 4'd0);
    endtask

    always @(posedge clk) begin
        m4 = mstep(m4, 4, rst_n, in_valid, in_bit, ch_mask);
        m1 = mstep(m1, 1, rst_n, in_valid, in_bit, ch_mask);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_model("d4", m4, bus4.in_ready, bus4.a, bus4.s, bus4.out_valid, bus4.rot_done, bus4.err_nomask);
            cmp_model("d1", m1, bus1.in_ready, bus1.a, bus1.s, bus1.out_valid, bus1.rot_done, bus1.err_nomask);
        end
    end

    // Four bits on the DWELL=4 instance: expected select per bit in exps, rotation ends in rot.
    task automatic stream4(string tag, logic [3:0] mask, logic [3:0] bits,
                           logic [7:0] exps, logic [3:0] rot);
        int k;
        ch_mask  = mask;
        in_valid = 1'b1;
        in_bit   = bits[0];
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            k = (c - 1) / 4;
            if (c % 4 == 1) begin
                if (k < 3) in_bit = bits[k + 1];
                else       in_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, ".s"},         bus4.s,         exps[2*k +: 2]);
            chk({tag, ".a"},         bus4.a,         bits[k]);
            chk({tag, ".out_valid"}, bus4.out_valid, 1);
            chk({tag, ".rot_done"},  bus4.rot_done,  (c % 4 == 0) && rot[k]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".idle_ov"}, bus4.out_valid, 0);
        chk({tag, ".idle_a"},  bus4.a,         0);
    endtask

    initial begin
        m4 = mreset();
        m1 = mreset();
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; ch_mask = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        ch_mask = 4'b1111;
        @(negedge clk);
        chk("reset.out_valid", bus4.out_valid, 0);
        chk("reset.a",         bus4.a,         0);
        chk("reset.s",         bus4.s,         0);
        chk("reset.rot_done",  bus4.rot_done,  0);
        chk("reset.in_ready",  bus4.in_ready,  0);
        rst_n = 1'b1;

        // basic rotation, then sparse mask continuing from ptr=3
        stream4("rot",    4'b1111, 4'b1101, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1000);
        stream4("sparse", 4'b1010, 4'b0110, {2'd3, 2'd1, 2'd3, 2'd1}, 4'b1010);

        // mask change mid-HOLD
        ch_mask = 4'b1111; in_valid = 1'b1; in_bit = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_bit = 1'b0;
            if (c == 2) ch_mask = 4'b0100;
            if (c == 5) in_valid = 1'b0;
            @(negedge clk);
            chk("mchg.s",        bus4.s,        (c <= 4) ? 0 : 2);
            chk("mchg.a",        bus4.a,        (c <= 4) ? 1 : 0);
            chk("mchg.rot_done", bus4.rot_done, c == 8);
        end
        @(posedge clk); #1;

        // zero mask
        ch_mask = 4'd0; in_valid = 1'b1; in_bit = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("zmask.in_ready",   bus4.in_ready,   0);
            chk("zmask.err_nomask", bus4.err_nomask, 1);
            chk("zmask.out_valid",  bus4.out_valid,  0);
            chk("zmask.a",          bus4.a,          0);
        end
        @(posedge clk); #1;
        ch_mask = 4'b0001;
        @(negedge clk);
        chk("zmask.ready_back", bus4.in_ready,   1);
        chk("zmask.err_clear",  bus4.err_nomask, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("zmask.s",  bus4.s,         0);
        chk("zmask.ov", bus4.out_valid, 1);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("zmask.idle", bus4.out_valid, 0);

        // reset in the second dwell cycle of channel 2
        ch_mask = 4'b0100; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rsth.s",  bus4.s,         2);
        chk("rsth.ov", bus4.out_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsth.in_ready_low", bus4.in_ready,  0);
        chk("rsth.ov_before",    bus4.out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsth.ov_after", bus4.out_valid, 0);
        chk("rsth.a_after",  bus4.a,         0);
        chk("rsth.s_after",  bus4.s,         0);
        ch_mask = 4'b1111; in_valid = 1'b1; in_bit = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rsth.first_s", bus4.s,         0);
        chk("rsth.first_v", bus4.out_valid, 1);
        repeat (4) @(posedge clk);
        #1;

        // DWELL=1 with a one-cycle gap in in_valid
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ch_mask = 4'b1111; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_bit = 1'b0;
        @(negedge clk);
        chk("d1.b0_ov", bus1.out_valid, 1);
        chk("d1.b0_s",  bus1.s,         0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("d1.b1_ov", bus1.out_valid, 1);
        chk("d1.b1_s",  bus1.s,         1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_bit = 1'b1;
        @(negedge clk);
        chk("d1.gap_ov", bus1.out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("d1.b2_ov", bus1.out_valid, 1);
        chk("d1.b2_s",  bus1.s,         2);
        chk("d1.b2_a",  bus1.a,         1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("d1.end_ov", bus1.out_valid, 0);

        repeat (6) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/demux_rr_sequencer.md
# demux_rr_sequencer

Upstream driver for the 1-to-4 demultiplexer stage. It accepts a serial stream of data bits over a valid/ready handshake and distributes them round-robin across the enabled output channels. For each accepted bit it drives the demux data input `a` and the select `s`, and holds both stable for a programmable dwell time so the downstream channel sees a clean level. It also flags rotation completion and the all-channels-disabled error.

## Interface
Parameters:
- `DWELL`, 4: cycles each accepted bit is held on `a`/`s`. Legal range 1..255.
- `CW`, 8: width of the dwell counter. Must satisfy `DWELL <= 2^CW - 1`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `in_valid`  in  1  upstream has a bit to send.
- `in_bit`  in  1  data bit; sampled on accept.
- `in_ready`  out  1  block can accept this cycle (combinational).
- `ch_mask`  in  4  channel enables, bit i = channel i; sampled only on accept.
- `a`  out  1  data to the demux.
- `s`  out  2  channel select to the demux.
- `out_valid`  out  1  `a`/`s` carry a live bit this cycle.
- `rot_done`  out  1  one-cycle pulse when the last enabled channel of a rotation finishes its dwell.
- `err_nomask`  out  1  `in_valid` high while `ch_mask == 0` (combinational).

## Operation
- State machine: IDLE and HOLD. Register `ptr[1:0]` holds the last channel served.
- `in_ready = (ch_mask != 0) && (state == IDLE || (state == HOLD && cnt == 0))`.
- Accept occurs when `in_valid && in_ready`. On accept:
  - `a <= in_bit`
  - `s <= nxt`, where `nxt` is the first set bit of `ch_mask` scanning cyclically from `ptr+1` (order 0→1→2→3→0)
  - `ptr <= nxt`
  - `cnt <= DWELL-1`
  - `last <= (no set bit of ch_mask above index nxt)`
  - state goes to HOLD.
- HOLD:
  - `out_valid = 1`.
  - If `cnt != 0`: `cnt` decrements.
  - If `cnt == 0`: dwell ends this cycle. `rot_done = last`. Next state is HOLD if an accept occurs this cycle (back-to-back), otherwise IDLE.
- IDLE:
  - `out_valid = 0`, `a = 0`, `s` holds its last value, `rot_done = 0`.
- `ch_mask == 0`:
  - No accept; `in_ready = 0`; `err_nomask = in_valid`.
  - A HOLD already in progress completes normally.
- Mask changes during HOLD have no effect on the current bit. They apply at the next accept.
- A single enabled channel selects that channel every time, and `rot_done` pulses on every bit.

## Timing
- Reset values (`rst_n` low at a rising edge): state IDLE, `ptr = 3` (so the first pick is the lowest enabled channel), `cnt = 0`, `a = 0`, `s = 0`, `out_valid = 0`, `rot_done = 0`, `last = 0`.
- While `rst_n` is low, `in_ready` is forced to 0.
- Reset mid-HOLD aborts the bit. Outputs take reset values on the next edge.
- Latency: accept at edge N. `a`/`s`/`out_valid` are valid from after edge N through the cycle before edge N+DWELL.
- Throughput: one bit per DWELL cycles with `in_valid` held high. `out_valid` stays continuously high across back-to-back bits.
- `DWELL = 1`: `in_ready` is high every cycle in HOLD, giving one bit per cycle.
- `rot_done` and `out_valid` are coincident in the final dwell cycle.
- `err_nomask` is combinational and has no registered side effects.

## Test plan
1. **Basic rotation.** Reset; `ch_mask = 4'b1111`, `DWELL = 4`, stream bits 1,0,1,1 with `in_valid` held high.
   - `s` = 0,1,2,3, each for 4 cycles.
   - `a` = 1,0,1,1.
   - `out_valid` stays high for 16 cycles.
   - `rot_done` pulses once, in cycle 16.
2. **Sparse mask.** `ch_mask = 4'b1010`, send 4 bits.
   - `s` = 1,3,1,3.
   - `rot_done` pulses at the end of the second and fourth bits.
3. **Mask change mid-HOLD.** Accept with `ch_mask = 4'b1111`, `s = 0`; switch to `4'b0100` during dwell.
   - Current bit stays on `s = 0` for its full dwell.
   - Next bit goes to `s = 2`.
4. **Zero mask.** `ch_mask = 0`, `in_valid = 1` for 5 cycles.
   - `in_ready = 0`, `err_nomask = 1`, `out_valid = 0`, `a = 0`.
   - Setting `ch_mask = 4'b0001` makes the bit accepted the next cycle with `s = 0`.
5. **Reset mid-HOLD.** Pull `rst_n` low in the 2nd dwell cycle of channel 2.
   - Next edge: `out_valid = 0`, `a = 0`, `s = 0`.
   - After release with mask `4'b1111`, the first bit goes to `s = 0`.
6. **`DWELL = 1` gaps.** `in_valid` pattern 1,1,0,1.
   - Bits go to `s` = 0,1,2.
   - `out_valid` is low for exactly one cycle, during the gap.
